calpoc_calc_core: RTL and testbench
===================================

# calpoc_calc_core

Parametrised successor to the fixed 3-bit CalPOC calculator top. It accepts operand bits and operator commands from push-button inputs, accumulates two WIDTH-bit operands A and B, and evaluates OR, XOR, AND or ADD on "equals". It drives operand LEDs and a multi-digit hex seven-segment display. It sits between the board button synchronisers and the LED/segment pins, and adds edge detection, entry limits, operator chaining and carry reporting.

## Interface
- WIDTH, 3, operand/result width in bits; legal range 1..16.
- DIGITS, (WIDTH+3)/4, number of hex digits shown (derived; do not override).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_one / btn_zero  in  1 each  enter bit 1 / bit 0 (level, pre-debounced, synchronous to clk).
- btn_or / btn_xor / btn_and / btn_add  in  1 each  operator select.
- btn_equals  in  1  evaluate.
- btn_clear  in  1  clear all.
- led_a  out  WIDTH  operand A register.
- led_b  out  WIDTH  operand B register.
- seg  out  7*DIGITS  active-high segments; digit d uses bits [7d+6:7d], ordered {g,f,e,d,c,b,a}; digit 0 = least-significant nibble.
- op_o  out  2  latched operator: 0 OR, 1 XOR, 2 AND, 3 ADD.
- carry  out  1  carry-out of last ADD; 0 after any other op.
- state_o  out  2  0 ENTER_A, 1 ENTER_B, 2 RESULT.

## Operation
- Edge detect: each button registered into btn_q; btn_q_d holds the previous value. Event = btn_q & ~btn_q_d. A held button yields exactly one event.
- One event is acted on per cycle, by priority: clear > equals > operator (or > xor > and > add) > one > zero. Lower-priority events in the same cycle are discarded.
- Bit entry shifts the active operand left and inserts the bit at the LSB. cnt tracks entered bits; once cnt==WIDTH, further bit events are ignored and the operand is unchanged.
- ENTER_A:
  - bit → shift into A.
  - operator → latch op, clear B and cnt, go to ENTER_B.
  - equals → ignored.
- ENTER_B:
  - bit → shift into B.
  - operator → replace op; B is kept.
  - equals → R = A op B, go to RESULT.
- RESULT:
  - bit → A=0, B=0, cnt=0, carry=0, then shift the bit into A; go to ENTER_A.
  - operator → A=R, B=0, cnt=0, latch op, go to ENTER_B (chaining).
  - equals → ignored; R is held.
- Clear, in any state, has the same effect as reset except for btn_q/btn_q_d.
- Arithmetic:
  - OR/XOR/AND are bitwise over WIDTH bits.
  - ADD is A+B modulo 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum.
- Display value: A in ENTER_A, B in ENTER_B, R in RESULT. It is zero-extended to 4*DIGITS bits, and each nibble is decoded to hex glyphs 0-F (standard a-g; "b" and "d" lowercase).

## Timing
- Reset: A, B, R, cnt, carry = 0; op_o = 0; state_o = 0; btn_q and btn_q_d = 0; seg shows all "0" (0111111 per digit).
- A button held through reset produces one event on the second cycle after rst falls.
- Button first sampled high at edge N lands in btn_q. The event is acted on at edge N+1, so A, B, R, op_o, state_o, carry and led_* are updated after N+1.
- seg is combinational from registered state, so it is valid after edge N+1 as well.
- rst asserted mid-entry or mid-result: all state returns to reset values at that edge; there is no partial update.
- Minimum press spacing: one low cycle between presses of the same button.

## Test plan
- Reset, then WIDTH=3: press 1,0,1, OR, 0,1,1, equals → led_a=101, led_b=011, state_o=2, seg=0000111 ("7"), carry=0.
- ADD overflow: A=110, ADD, B=011, equals → R=001, seg=0000110 ("1"), carry=1.
- Entry limit plus held button: press 1 four times with A empty → A=111, cnt saturates; hold btn_zero for 10 cycles in a fresh entry → exactly one shift.
- Chaining and priority: after R=111, press XOR, then 1,1,0, equals → R=001. btn_clear and btn_one rising in the same cycle → all state zero, A=000.
- Reset mid-entry: assert rst in ENTER_B with B=01 → led_a=led_b=0, state_o=0, op_o=0 after the next edge.
- WIDTH=8: A=0xA5, AND, B=0x3C, equals → R=0x24; seg digit1 = "2" (1011011), digit0 = "4" (1100110).

Source files
------------

// File: rtl/calpoc_calc_core.sv
// calpoc_calc_core: push-button calculator core with two WIDTH-bit operands,
// OR/XOR/AND/ADD evaluation, operator chaining and a multi-digit hex display.

// Hex nibble to seven-segment glyph, active-high, ordered {g,f,e,d,c,b,a}.
module calpoc_hex7 (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    // Glyph lookup; "b" and "d" are the lowercase forms.
    always_comb begin
        case (nib)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
    end
endmodule

module calpoc_calc_core #(
    parameter int WIDTH  = 3,
    parameter int DIGITS = (WIDTH + 3) / 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_one,
    input  logic                  btn_zero,
    input  logic                  btn_or,
    input  logic                  btn_xor,
    input  logic                  btn_and,
    input  logic                  btn_add,
    input  logic                  btn_equals,
    input  logic                  btn_clear,
    output logic [WIDTH-1:0]      led_a,
    output logic [WIDTH-1:0]      led_b,
    output logic [7*DIGITS-1:0]   seg,
    output logic [1:0]            op_o,
    output logic                  carry,
    output logic [1:0]            state_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = 4 * DIGITS;

    typedef struct packed {
        logic clear;
        logic equals;
        logic op_or;
        logic op_xor;
        logic op_and;
        logic op_add;
        logic one;
        logic zero;
    } btn_t;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        RESULT  = 2'd2
    } state_t;

    btn_t btn_now, btn_q, btn_q_d, evt;

    state_t           state, state_n;
    logic [WIDTH-1:0] a, a_n, b, b_n, r, r_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [1:0]       op, op_n;
    logic             carry_q, carry_n;

    logic             is_op, is_bit, bit_val, room;
    logic [1:0]       op_sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu;

    assign btn_now = '{clear: btn_clear, equals: btn_equals, op_or: btn_or,
                       op_xor: btn_xor, op_and: btn_and, op_add: btn_add,
                       one: btn_one, zero: btn_zero};
    assign evt = btn_t'(btn_q & ~btn_q_d);

    // Button capture and one-cycle history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q   <= '0;
            btn_q_d <= '0;
        end else begin
            btn_q   <= btn_now;
            btn_q_d <= btn_q;
        end
    end

    // Operator decode (or > xor > and > add), bit value (one beats zero) and ALU.
    always_comb begin
        is_op   = evt.op_or | evt.op_xor | evt.op_and | evt.op_add;
        is_bit  = evt.one | evt.zero;
        bit_val = evt.one;
        if (evt.op_or)       op_sel = 2'd0;
        else if (evt.op_xor) op_sel = 2'd1;
        else if (evt.op_and) op_sel = 2'd2;
        else                 op_sel = 2'd3;
        room = (cnt != CW'(WIDTH));
        sum  = {1'b0, a} + {1'b0, b};
        case (op)
            2'd0:    alu = a | b;
            2'd1:    alu = a ^ b;
            2'd2:    alu = a & b;
            default: alu = sum[WIDTH-1:0];
        endcase
    end

    // Next-state and datapath update; only the highest-priority event acts.
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        r_n     = r;
        cnt_n   = cnt;
        op_n    = op;
        carry_n = carry_q;
        if (evt.clear) begin
            state_n = ENTER_A;
            a_n     = '0;
            b_n     = '0;
            r_n     = '0;
            cnt_n   = '0;
            op_n    = 2'd0;
            carry_n = 1'b0;
        end else if (evt.equals) begin
            if (state == ENTER_B) begin
                r_n     = alu;
                carry_n = (op == 2'd3) ? sum[WIDTH] : 1'b0;
                state_n = RESULT;
            end
        end else if (is_op) begin
            op_n = op_sel;
            case (state)
                ENTER_A: begin
                    b_n     = '0;
                    cnt_n   = '0;
                    state_n = ENTER_B;
                end
                RESULT: begin
                    a_n     = r;
                    b_n     = '0;
                    cnt_n   = '0;
                    state_n = ENTER_B;
                end
                default: ;
            endcase
        end else if (is_bit) begin
            case (state)
                ENTER_A: begin
                    if (room) begin
                        a_n   = WIDTH'({a, bit_val});
                        cnt_n = cnt + CW'(1);
                    end
                end
                ENTER_B: begin
                    if (room) begin
                        b_n   = WIDTH'({b, bit_val});
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    // A new digit after a result starts a fresh calculation.
                    a_n     = WIDTH'(bit_val);
                    b_n     = '0;
                    cnt_n   = CW'(1);
                    carry_n = 1'b0;
                    state_n = ENTER_A;
                end
            endcase
        end
    end

    // State and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ENTER_A;
            a       <= '0;
            b       <= '0;
            r       <= '0;
            cnt     <= '0;
            op      <= 2'd0;
            carry_q <= 1'b0;
        end else begin
            state   <= state_n;
            a       <= a_n;
            b       <= b_n;
            r       <= r_n;
            cnt     <= cnt_n;
            op      <= op_n;
            carry_q <= carry_n;
        end
    end

    logic [DW-1:0]         disp;
    logic [DIGITS-1:0][6:0] glyph;

    // Display source follows the phase of the calculation.
    always_comb begin
        case (state)
            ENTER_A: disp = DW'(a);
            ENTER_B: disp = DW'(b);
            default: disp = DW'(r);
        endcase
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        calpoc_hex7 u_hex (
            .nib (disp[4*d +: 4]),
            .seg (glyph[d])
        );
    end

    assign seg     = glyph;
    assign led_a   = a;
    assign led_b   = b;
    assign op_o    = op;
    assign carry   = carry_q;
    assign state_o = state;
endmodule

// File: tb/tb_calpoc_calc_core.sv
// Directed bench for calpoc_calc_core at WIDTH=3 and WIDTH=8 with a scoreboard.
module tb_calpoc_calc_core;
    localparam logic [7:0] M_ZERO = 8'h01, M_ONE = 8'h02, M_ADD = 8'h04, M_AND = 8'h08;
    localparam logic [7:0] M_XOR  = 8'h10, M_OR  = 8'h20, M_EQ  = 8'h40, M_CLR = 8'h80;

    typedef struct {
        string      tag;
        logic       w8;
        logic [7:0] a, b;
        logic [1:0] st, op;
        logic       cy;
        logic [13:0] seg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] btn = '0;

    logic [2:0]  a3, b3;
    logic [6:0]  seg3;
    logic [1:0]  op3, st3;
    logic        cy3;
    logic [7:0]  a8, b8;
    logic [13:0] seg8;
    logic [1:0]  op8, st8;
    logic        cy8;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    calpoc_calc_core #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst),
        .btn_one(btn[1]), .btn_zero(btn[0]), .btn_or(btn[5]), .btn_xor(btn[4]),
        .btn_and(btn[3]), .btn_add(btn[2]), .btn_equals(btn[6]), .btn_clear(btn[7]),
        .led_a(a3), .led_b(b3), .seg(seg3), .op_o(op3), .carry(cy3), .state_o(st3)
    );

    calpoc_calc_core #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .btn_one(btn[1]), .btn_zero(btn[0]), .btn_or(btn[5]), .btn_xor(btn[4]),
        .btn_and(btn[3]), .btn_add(btn[2]), .btn_equals(btn[6]), .btn_clear(btn[7]),
        .led_a(a8), .led_b(b8), .seg(seg8), .op_o(op8), .carry(cy8), .state_o(st8)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[n];
    endfunction

    // Expected outcome of the next 3-bit step; r is the result register value.
    task automatic push3(input string tag, input logic [7:0] a, b, r,
                         input logic [1:0] st, op, input logic cy);
        exp_t e;
        logic [7:0] d;
        d = (st == 2'd0) ? a : (st == 2'd1) ? b : r;
        e = '{tag: tag, w8: 1'b0, a: a, b: b, st: st, op: op, cy: cy,
              seg: {7'h00, glyph(d[3:0])}};
        sb.push_back(e);
    endtask

    task automatic push8(input string tag, input logic [7:0] a, b, r,
                         input logic [1:0] st, op, input logic cy);
        exp_t e;
        logic [7:0] d;
        d = (st == 2'd0) ? a : (st == 2'd1) ? b : r;
        e = '{tag: tag, w8: 1'b1, a: a, b: b, st: st, op: op, cy: cy,
              seg: {glyph(d[7:4]), glyph(d[3:0])}};
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string fld, input logic [15:0] obs, exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare against the DUT it targets.
    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        if (e.w8) begin
            cmp(e.tag, "led_a", 16'(a8), 16'(e.a));
            cmp(e.tag, "led_b", 16'(b8), 16'(e.b));
            cmp(e.tag, "state", 16'(st8), 16'(e.st));
            cmp(e.tag, "op", 16'(op8), 16'(e.op));
            cmp(e.tag, "carry", 16'(cy8), 16'(e.cy));
            cmp(e.tag, "seg", 16'(seg8), 16'(e.seg));
        end else begin
            cmp(e.tag, "led_a", 16'(a3), 16'(e.a));
            cmp(e.tag, "led_b", 16'(b3), 16'(e.b));
            cmp(e.tag, "state", 16'(st3), 16'(e.st));
            cmp(e.tag, "op", 16'(op3), 16'(e.op));
            cmp(e.tag, "carry", 16'(cy3), 16'(e.cy));
            cmp(e.tag, "seg", 16'(seg3), 16'(e.seg));
        end
    endtask

    // One-cycle press; returns at the negedge after the acting edge.
    task automatic tap(input logic [7:0] m);
        @(negedge clk) btn = m;
        @(posedge clk);
        @(negedge clk) btn = '0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic s3(input string tag, input logic [7:0] m, input logic [7:0] a, b, r,
                      input logic [1:0] st, op, input logic cy);
        push3(tag, a, b, r, st, op, cy);
        tap(m);
        check();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        push3("rst3", 0, 0, 0, 0, 0, 0); check();
        push8("rst8", 0, 0, 0, 0, 0, 0); check();

        // 101 OR 011 = 111
        s3("a1",    M_ONE,  1, 0, 0, 0, 0, 0);
        s3("a10",   M_ZERO, 2, 0, 0, 0, 0, 0);
        s3("a101",  M_ONE,  5, 0, 0, 0, 0, 0);
        s3("eq_ia", M_EQ,   5, 0, 0, 0, 0, 0);
        s3("or",    M_OR,   5, 0, 0, 1, 0, 0);
        s3("b0",    M_ZERO, 5, 0, 0, 1, 0, 0);
        s3("b01",   M_ONE,  5, 1, 0, 1, 0, 0);
        s3("b011",  M_ONE,  5, 3, 0, 1, 0, 0);
        s3("eq_or", M_EQ,   5, 3, 7, 2, 0, 0);

        // chain: 111 XOR 110 = 001
        s3("xor_ch", M_XOR, 7, 0, 7, 1, 1, 0);
        s3("xb1",    M_ONE, 7, 1, 7, 1, 1, 0);
        s3("xb11",   M_ONE, 7, 3, 7, 1, 1, 0);
        s3("xb110",  M_ZERO,7, 6, 7, 1, 1, 0);
        s3("eq_xor", M_EQ,  7, 6, 1, 2, 1, 0);

        // fresh entry from RESULT, then 110 ADD 011 overflows
        s3("ra1",    M_ONE, 1, 0, 1, 0, 1, 0);
        s3("ra11",   M_ONE, 3, 0, 1, 0, 1, 0);
        s3("ra110",  M_ZERO,6, 0, 1, 0, 1, 0);
        s3("add",    M_ADD, 6, 0, 1, 1, 3, 0);
        s3("ab0",    M_ZERO,6, 0, 1, 1, 3, 0);
        s3("ab01",   M_ONE, 6, 1, 1, 1, 3, 0);
        s3("ab011",  M_ONE, 6, 3, 1, 1, 3, 0);
        s3("eq_add", M_EQ,  6, 3, 1, 2, 3, 1);

        // entry limit
        s3("clr1",   M_CLR, 0, 0, 0, 0, 0, 0);
        s3("lim1",   M_ONE, 1, 0, 0, 0, 0, 0);
        s3("lim2",   M_ONE, 3, 0, 0, 0, 0, 0);
        s3("lim3",   M_ONE, 7, 0, 0, 0, 0, 0);
        s3("lim4",   M_ONE, 7, 0, 0, 0, 0, 0);

        // held button gives one shift
        s3("clr2",   M_CLR, 0, 0, 0, 0, 0, 0);
        s3("h1",     M_ONE, 1, 0, 0, 0, 0, 0);
        push3("hold0", 2, 0, 0, 0, 0, 0);
        @(negedge clk) btn = M_ZERO;
        repeat (10) @(posedge clk);
        @(negedge clk) btn = '0;
        @(posedge clk);
        @(negedge clk);
        check();

        // priorities
        s3("p_or",   M_OR,         2, 0, 0, 1, 0, 0);
        s3("p_b1",   M_ONE,        2, 1, 0, 1, 0, 0);
        s3("eq_one", M_EQ | M_ONE, 2, 1, 3, 2, 0, 0);
        s3("xor_add",M_XOR | M_ADD,3, 0, 3, 1, 1, 0);
        s3("pb1",    M_ONE,        3, 1, 3, 1, 1, 0);
        s3("pb10",   M_ZERO,       3, 2, 3, 1, 1, 0);
        s3("clr_one",M_CLR | M_ONE,0, 0, 0, 0, 0, 0);

        // reset mid-entry with B=01
        s3("m_a1",   M_ONE,  1, 0, 0, 0, 0, 0);
        s3("m_and",  M_AND,  1, 0, 0, 1, 2, 0);
        s3("m_b0",   M_ZERO, 1, 0, 0, 1, 2, 0);
        s3("m_b01",  M_ONE,  1, 1, 0, 1, 2, 0);
        push3("midrst", 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check();

        // WIDTH=8: A5 AND 3C = 24
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'hA5;
            tap(v[i] ? M_ONE : M_ZERO);
        end
        push8("w8_a", 8'hA5, 0, 0, 0, 0, 0); check();
        push8("w8_and", 8'hA5, 0, 0, 1, 2, 0);
        tap(M_AND);
        check();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'h3C;
            tap(v[i] ? M_ONE : M_ZERO);
        end
        push8("w8_eq", 8'hA5, 8'h3C, 8'h24, 2, 2, 0);
        tap(M_EQ);
        check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
